// File: rtl/immed_pkg.sv
// Shared types and constants for the RV32I immediate encoder.
// Range checking is compiled in only with IMMED_ENC_CHECK_EN defined.
package immed_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4
  } fmt_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  // High bits must be a pure sign extension of the field's top bit.
  function automatic logic imm_range_err(
    input logic [2:0]  f,
    input logic [31:0] imm
  );
    logic err;
    err = 1'b0;
    unique case (1'b1)
      (f == FMT_I), (f == FMT_S):
        err = !(&imm[31:11] || ~|imm[31:11]);
      (f == FMT_B):
        err = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
      (f == FMT_U):
        err = |imm[11:0];
      (f == FMT_J):
        err = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
      default:
        err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/immed_pack.sv
// Combinational RV32I field packer with illegal-format and range flag.
// Range flag is active only with IMMED_ENC_CHECK_EN defined.
module immed_pack
  import immed_pkg::*;
(
  input  req_t        req,
  output logic [31:0] ir,
  output logic        err
);

  logic rng;

`ifdef IMMED_ENC_CHECK_EN
  assign rng = imm_range_err(req.fmt, req.imm);
`else
  assign rng = 1'b0;
`endif

  always_comb begin
    ir  = NOP_INSTR;
    err = 1'b1;
    unique case (1'b1)
      (req.fmt == FMT_I): begin
        ir  = {req.imm[11:0], req.rs1, req.funct3,
               req.rd, req.opcode};
        err = rng;
      end
      (req.fmt == FMT_S): begin
        ir  = {req.imm[11:5], req.rs2, req.rs1,
               req.funct3, req.imm[4:0], req.opcode};
        err = rng;
      end
      (req.fmt == FMT_B): begin
        ir  = {req.imm[12], req.imm[10:5], req.rs2,
               req.rs1, req.funct3, req.imm[4:1],
               req.imm[11], req.opcode};
        err = rng;
      end
      (req.fmt == FMT_U): begin
        ir  = {req.imm[31:12], req.rd, req.opcode};
        err = rng;
      end
      (req.fmt == FMT_J): begin
        ir  = {req.imm[20], req.imm[10:1], req.imm[11],
               req.imm[19:12], req.rd, req.opcode};
        err = rng;
      end
      default: begin
        ir  = NOP_INSTR;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/immed_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with output counter.
// Range checking is compiled in only with IMMED_ENC_CHECK_EN defined.
module immed_encoder
  import immed_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       FMT,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic [4:0]       RD,
  input  logic [4:0]       RS1,
  input  logic [4:0]       RS2,
  input  logic [31:0]      IMM,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      IR,
  output logic             ERR,
  output logic [CNT_W-1:0] ENC_COUNT
);

  req_t             in_req;
  req_t             s1_q;
  logic             in_rerr;
  logic             s1_valid;
  logic             s1_rerr;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [31:0]      pk_ir;
  logic             pk_err;
  logic [31:0]      ir_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  assign in_req = '{
    fmt:    FMT,
    opcode: OPCODE,
    funct3: FUNCT3,
    rd:     RD,
    rs1:    RS1,
    rs2:    RS2,
    imm:    IMM
  };

`ifdef IMMED_ENC_CHECK_EN
  assign in_rerr = imm_range_err(FMT, IMM);
`else
  assign in_rerr = 1'b0;
`endif

  assign s2_adv   = !s2_valid || OUT_READY;
  assign s1_adv   = !s1_valid || s2_adv;
  assign IN_READY = s1_adv;

  immed_pack u_pack (
    .req (s1_q),
    .ir  (pk_ir),
    .err (pk_err)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_rerr  <= 1'b0;
      s2_valid <= 1'b0;
      ir_q     <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= IN_VALID;
        if (IN_VALID) begin
          s1_q    <= in_req;
          s1_rerr <= in_rerr;
        end
      end
      // S2 payload only moves when S2 is empty or being drained.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          ir_q  <= pk_ir;
          err_q <= pk_err | s1_rerr;
        end
      end
      if (s2_valid && OUT_READY)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign OUT_VALID = s2_valid;
  assign IR        = ir_q;
  assign ERR       = err_q;
  assign ENC_COUNT = cnt_q;

endmodule

// File: doc/immed_encoder.md
Name: immed_encoder

Overview:
- Inverse of the OTTER immediate generator: packs a 32-bit immediate plus register, funct3 and opcode fields into a 32-bit RV32I instruction word for I, S, B, U and J formats.
- Used by the self-test and boot-loader path to build instruction words in hardware, and as a round-trip reference for verifying immediate decode.
- Two-stage valid/ready pipeline with backpressure, a representability check on the immediate, and an accepted-word counter.

Parameters:
- CNT_W, 16, width of the ENC_COUNT output counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  input request valid.
- IN_READY  out  1  block can accept a request this cycle.
- FMT  in  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J; 5-7 are illegal.
- OPCODE  in  7  placed in IR[6:0].
- FUNCT3  in  3  placed in IR[14:12] for I, S and B formats.
- RD  in  5  destination register, used by I, U and J formats.
- RS1  in  5  source register 1, used by I, S and B formats.
- RS2  in  5  source register 2, used by S and B formats.
- IMM  in  32  immediate value as the decoder would produce it, sign-extended.
- OUT_VALID  out  1  encoded word valid.
- OUT_READY  in  1  downstream accepts the word.
- IR  out  32  encoded instruction.
- ERR  out  1  immediate not representable, or illegal FMT; qualified by OUT_VALID.
- ENC_COUNT  out  CNT_W  number of words accepted downstream (OUT_VALID&&OUT_READY); wraps.

Behaviour:
- Reset (asynchronous, RST_N=0): both stage valids=0, OUT_VALID=0, IR=0, ERR=0, ENC_COUNT=0. IN_READY is 1 once reset is released.
- Stage 1 (S1) registers the request and the range-check result. Stage 2 (S2) registers the packed IR and ERR, which drive the outputs.
- Latency: 2 cycles from an accepted input to OUT_VALID when not stalled. Throughput is 1 word per cycle.
- Handshake:
  - s2_adv = !s2_valid || OUT_READY.
  - s1_adv = !s1_valid || s2_adv.
  - IN_READY = s1_adv, computed combinationally.
  - A transfer occurs on VALID&&READY at either end.
  - OUT_VALID, IR and ERR must hold stable while OUT_VALID && !OUT_READY.
- Simultaneous events: an input accept, an S1-to-S2 move and an output accept may all happen in the same cycle with no bubble. Capacity is 2 words; the block never drops or reorders words.
- Packing:
  - I: IR = {IMM[11:0], RS1, FUNCT3, RD, OPCODE}.
  - S: IR = {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE}.
  - B: IR = {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE}.
  - U: IR = {IMM[31:12], RD, OPCODE}.
  - J: IR = {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE}.
  - Illegal FMT: IR = 32'h0000_0013 (NOP) and ERR=1.
- Range check (ERR=1 on failure; IR is still packed from the truncated fields):
  - I and S: IMM[31:11] are all equal.
  - B: IMM[31:12] are all equal and IMM[0]=0.
  - U: IMM[11:0]=0.
  - J: IMM[31:20] are all equal and IMM[0]=0.
- ENC_COUNT increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0. Error words are counted too.
- Reset mid-operation flushes both stages; no partially encoded word is ever emitted.

Optional Feature:
- Macro: IMMED_ENC_CHECK_EN.
- Defined: range checking operates as described above.
- Undefined: the range logic is removed. Immediates are truncated silently and ERR is 1 only for an illegal FMT.

Decomposition:
- Package immed_pkg:
  - fmt_e enum (FMT_I=0, FMT_S, FMT_B, FMT_U, FMT_J).
  - NOP_INSTR=32'h0000_0013.
  - Opcode constants OP_IMM=7'h13, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_LUI=7'h37, OP_JAL=7'h6F.
- Sub-module immed_pack: combinational packer plus range check (fields in -> IR, range_err). It is instantiated between S1 and S2 and is reusable by verification models.

Test Plan:
- I: FMT=0, OPCODE=0x13, FUNCT3=0, RD=1, RS1=0, IMM=0xFFFFFFFF -> IR=0xFFF00093, ERR=0, OUT_VALID 2 cycles after accept.
- S/B:
  - FMT=1, OPCODE=0x23, FUNCT3=2, RS1=1, RS2=2, IMM=8 -> IR=0x0020A423.
  - FMT=2, OPCODE=0x63, all register fields 0, IMM=0xFFFFFFFC -> IR=0xFE000EE3.
- U: FMT=3, OPCODE=0x37, RD=5, IMM=0x12345000 -> IR=0x123452B7, ERR=0.
- Errors:
  - J with IMM=0x00100000 -> ERR=1.
  - B with IMM=3 -> ERR=1.
  - FMT=6 -> IR=0x00000013, ERR=1.
  - With IMMED_ENC_CHECK_EN undefined, the first two cases give ERR=0.
- Backpressure and reset:
  - Hold OUT_READY=0 while offering 3 back-to-back words -> IN_READY=0 after 2 accepts, and IR stays stable.
  - Release OUT_READY -> words come out in order and ENC_COUNT=3.
  - Assert RST_N=0 mid-stream -> OUT_VALID=0 and ENC_COUNT=0 immediately.
